spm_way_init_ctrl: RTL and testbench
====================================

// Module: spm_way_init_ctrl
// PURPOSE
//  Sequences reconfiguration of cache ways into/out of SPM mode. Ways being
//  removed from the SPM set are revoked at once. Ways being added are first
//  zero-filled, line by line, including the data and tag fields. Only then are
//  they published on active_ways_o. That output feeds the I/D SPM controllers.
//  Sits between the SPM config CSR and the per-way SRAM arbitration mux.
// PARAMETERS
//  NR_WAYS        4    number of cache ways / SRAM macros
//  NUM_LINES      256  lines per way (power of two, >=2)
//  MEMORY_WIDTH   173  SRAM word width (line + tag + valid)
//  NR_WAIT_STAGES 1    cycles for in-flight SPM accesses to retire (>=1)
// PORTS
//  clk_i          in   1                clock
//  rst_i          in   1                async reset, active-high
//  cfg_ways_i     in   NR_WAYS          requested SPM way mask
//  cfg_valid_i    in   1                request a new mask
//  cfg_ready_o    out  1                controller idle; accepts cfg
//  active_ways_o  out  NR_WAYS          ways usable as SPM
//  hold_o         out  1                stall new SPM fetch/LSU requests
//  done_o         out  1                1-cycle pulse on mask publication
//  mem_req_o      out  NR_WAYS          per-way SRAM request
//  mem_gnt_i      in   1                arbiter grants this cycle's write
//  mem_addr_o     out  $clog2(NUM_LINES) line index (shared by all ways)
//  mem_wdata_o    out  MEMORY_WIDTH     always '0
//  mem_we_o       out  1                always 1 while mem_req_o != 0
//  mem_be_o       out  (MEMORY_WIDTH+7)/8 always all-ones
// BEHAVIOUR
//  Reset values:
//  - FSM=IDLE, active_ways_o='0, hold_o=0, done_o=0, mem_req_o='0,
//    mem_addr_o='0, cfg_ready_o=1.
//  States IDLE, DRAIN, CLEAR, COMMIT. cfg_ready_o=1 only in IDLE.
//  IDLE, on cfg_valid_i:
//  - Latch add_q = cfg_ways_i & ~active_ways_o.
//  - Latch keep_q = cfg_ways_i & active_ways_o.
//  - Next cycle: active_ways_o <= keep_q (removal is immediate). Wait
//    counter <= NR_WAIT_STAGES. Go to DRAIN.
//  - If add_q=='0, go straight to COMMIT. No DRAIN and no SRAM access.
//  DRAIN:
//  - hold_o=1. Decrement the counter each cycle.
//  - At counter==1, go to CLEAR with line counter=0.
//  CLEAR:
//  - hold_o=1. mem_req_o=add_q. mem_addr_o=line counter.
//  - Line counter advances only on mem_gnt_i. Without a grant, hold the
//    address and request (no skipped lines).
//  - On mem_gnt_i at line NUM_LINES-1, go to COMMIT. No counter wrap.
//  COMMIT:
//  - hold_o=1 for this cycle.
//  - Next cycle: active_ways_o <= keep_q | add_q, done_o=1 for 1 cycle,
//    go to IDLE.
//  Latency: accept -> done_o = 1 + NR_WAIT_STAGES + NUM_LINES + 1 cycles
//  when every request is granted. With add_q=='0 it is 2 cycles.
//  cfg_valid_i outside IDLE is ignored; the requester must hold it until
//  accepted. The same mask as active_ways_o completes with no SRAM access.
//  Reset mid-CLEAR: all state cleared and active_ways_o='0. Partially
//  zeroed ways stay unpublished.
// STRUCTURE
//  - spm_init_state_t enum and the SPM_INIT_LINES_W constant go in
//    wt_cache_pkg.
//  - One FSM with two counters (wait, line). No sub-module needed.
//  - The SRAM mux gives this block priority while hold_o=1.
// TESTING
//  1. Reset, cfg 4'b0011, gnt=1 -> 256 writes to ways 0,1 with addr 0..255,
//     wdata 0, be all-ones. done_o at cycle 259; active=0011.
//  2. From active=0011, cfg 4'b0001 -> active=0001 one cycle after accept.
//     done_o 2 cycles after accept; no mem_req_o.
//  3. From active=0001, cfg 4'b0110 -> active=0000 after accept. Way 1 is
//     zeroed, way 2 cleared, way 0 not. Final active=0110.
//  4. gnt toggled 1/0 in CLEAR -> each addr written exactly once, in order.
//     done_o delayed by the number of denied cycles.
//  5. cfg_valid_i pulsed during CLEAR -> ignored; cfg_ready_o=0 throughout.
//     The first mask completes unchanged.
//  6. rst_i asserted at line 100 -> outputs reach reset values
//     asynchronously; active stays 0000 after release.

Source files
------------

// File: rtl/wt_cache_pkg.sv
// Shared cache/SPM types: the way-init sequencer state encoding and line-index width.
package wt_cache_pkg;

    typedef enum logic [1:0] {
        SPM_INIT_IDLE,
        SPM_INIT_DRAIN,
        SPM_INIT_CLEAR,
        SPM_INIT_COMMIT
    } spm_init_state_t;

    localparam int unsigned SPM_INIT_NUM_LINES = 256;
    localparam int unsigned SPM_INIT_LINES_W   = $clog2(SPM_INIT_NUM_LINES);

endpackage

// File: rtl/spm_way_init_ctrl.sv
// Sequences cache ways into/out of SPM mode: removals take effect at once,
// additions are zero-filled line by line before being published.
module spm_way_init_ctrl
    import wt_cache_pkg::*;
#(
    parameter int unsigned NR_WAYS        = 4,
    parameter int unsigned NUM_LINES      = SPM_INIT_NUM_LINES,
    parameter int unsigned MEMORY_WIDTH   = 173,
    parameter int unsigned NR_WAIT_STAGES = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NR_WAYS-1:0]              cfg_ways_i,
    input  logic                            cfg_valid_i,
    output logic                            cfg_ready_o,
    output logic [NR_WAYS-1:0]              active_ways_o,
    output logic                            hold_o,
    output logic                            done_o,
    output logic [NR_WAYS-1:0]              mem_req_o,
    input  logic                            mem_gnt_i,
    output logic [$clog2(NUM_LINES)-1:0]    mem_addr_o,
    output logic [MEMORY_WIDTH-1:0]         mem_wdata_o,
    output logic                            mem_we_o,
    output logic [(MEMORY_WIDTH+7)/8-1:0]   mem_be_o
);

    localparam int unsigned LINE_W = $clog2(NUM_LINES);
    localparam int unsigned WAIT_W = $clog2(NR_WAIT_STAGES + 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_LINES - 1);

    spm_init_state_t     state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [NR_WAYS-1:0]  add_q, add_d;
    logic [NR_WAYS-1:0]  keep_q, keep_d;
    logic [NR_WAYS-1:0]  active_q, active_d;
    logic                done_q, done_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= SPM_INIT_IDLE;
            wait_q   <= '0;
            line_q   <= '0;
            add_q    <= '0;
            keep_q   <= '0;
            active_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            line_q   <= line_d;
            add_q    <= add_d;
            keep_q   <= keep_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        line_d      = line_q;
        add_d       = add_q;
        keep_d      = keep_q;
        active_d    = active_q;
        done_d      = 1'b0;
        cfg_ready_o = 1'b0;
        hold_o      = 1'b0;
        mem_req_o   = '0;

        case (state_q)
            SPM_INIT_IDLE: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i) begin
                    add_d    = cfg_ways_i & ~active_q;
                    keep_d   = cfg_ways_i & active_q;
                    // Revoked ways disappear immediately; new ones wait for the fill.
                    active_d = keep_d;
                    wait_d   = WAIT_W'(NR_WAIT_STAGES);
                    state_d  = (add_d == '0) ? SPM_INIT_COMMIT : SPM_INIT_DRAIN;
                end
            end
            SPM_INIT_DRAIN: begin
                hold_o = 1'b1;
                wait_d = wait_q - WAIT_W'(1);
                if (wait_q == WAIT_W'(1)) begin
                    state_d = SPM_INIT_CLEAR;
                    line_d  = '0;
                end
            end
            SPM_INIT_CLEAR: begin
                hold_o    = 1'b1;
                mem_req_o = add_q;
                // A denied write holds the address so no line is skipped.
                if (mem_gnt_i) begin
                    if (line_q == LAST_LINE) begin
                        state_d = SPM_INIT_COMMIT;
                    end else begin
                        line_d = line_q + LINE_W'(1);
                    end
                end
            end
            SPM_INIT_COMMIT: begin
                hold_o   = 1'b1;
                active_d = keep_q | add_q;
                done_d   = 1'b1;
                state_d  = SPM_INIT_IDLE;
            end
            default: begin
                state_d = SPM_INIT_IDLE;
            end
        endcase
    end

    assign active_ways_o = active_q;
    assign done_o        = done_q;
    assign mem_addr_o    = line_q;
    assign mem_wdata_o   = '0;
    assign mem_we_o      = (mem_req_o != '0);
    assign mem_be_o      = '1;

endmodule

// File: tb/tb_spm_way_init_ctrl.sv
// Bench for spm_way_init_ctrl: randomized grants/masks checked against a mask-level model.
module tb_spm_way_init_ctrl;

    localparam int NR_WAYS        = 4;
    localparam int NUM_LINES      = 256;
    localparam int MEMORY_WIDTH   = 173;
    localparam int NR_WAIT_STAGES = 1;
    localparam int LINE_W         = $clog2(NUM_LINES);
    localparam int BE_W           = (MEMORY_WIDTH + 7) / 8;

    logic                    clk = 1'b0;
    logic                    rst_i;
    logic [NR_WAYS-1:0]      cfg_ways_i;
    logic                    cfg_valid_i;
    logic                    cfg_ready_o;
    logic [NR_WAYS-1:0]      active_ways_o;
    logic                    hold_o;
    logic                    done_o;
    logic [NR_WAYS-1:0]      mem_req_o;
    logic                    mem_gnt_i;
    logic [LINE_W-1:0]       mem_addr_o;
    logic [MEMORY_WIDTH-1:0] mem_wdata_o;
    logic                    mem_we_o;
    logic [BE_W-1:0]         mem_be_o;

    spm_way_init_ctrl #(
        .NR_WAYS        (NR_WAYS),
        .NUM_LINES      (NUM_LINES),
        .MEMORY_WIDTH   (MEMORY_WIDTH),
        .NR_WAIT_STAGES (NR_WAIT_STAGES)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cfg_ways_i    (cfg_ways_i),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_ready_o   (cfg_ready_o),
        .active_ways_o (active_ways_o),
        .hold_o        (hold_o),
        .done_o        (done_o),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: the mask currently published, and per-way/per-line write counts.
    logic [NR_WAYS-1:0] exp_active;
    int                 wr_cnt [NR_WAYS][NUM_LINES];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One reconfiguration. gnt_mode: 0 always grant, 1 alternate 1/0, 2 random.
    // stop_line >= 0 returns mid-fill once that many lines have been written.
    task automatic run_txn(input logic [NR_WAYS-1:0] mask, input int gnt_mode,
                           input bit poke_cfg, input int stop_line);
        logic [NR_WAYS-1:0] add, keep;
        int  c, denied, writes, exp_done, ctl_err, wr_err, req_err, cnt_err;
        bit  done_seen, aborted, tog, g;

        add  = mask & ~exp_active;
        keep = mask & exp_active;
        for (int w = 0; w < NR_WAYS; w++)
            for (int l = 0; l < NUM_LINES; l++)
                wr_cnt[w][l] = 0;

        tests_run++;
        if (cfg_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_before_cfg: got %b, want 1", cfg_ready_o);
        end

        cfg_ways_i  = mask;
        cfg_valid_i = 1'b1;
        step();
        cfg_valid_i = 1'b0;
        c = 1;

        tests_run++;
        if (active_ways_o !== keep) begin
            tests_failed++;
            $display("FAIL active_after_accept: got %b, want %b", active_ways_o, keep);
        end

        denied = 0; writes = 0; tog = 1'b1; done_seen = 1'b0; aborted = 1'b0;
        ctl_err = 0; wr_err = 0; req_err = 0;
        while (!done_seen && c < 4 * NUM_LINES + 50) begin
            mem_gnt_i   = 1'b0;
            cfg_valid_i = 1'b0;
            if (done_o === 1'b1) begin
                done_seen = 1'b1;
                exp_done  = (add == '0) ? 2 : 2 + NR_WAIT_STAGES + NUM_LINES + denied;
                tests_run++;
                if (c !== exp_done) begin
                    tests_failed++;
                    $display("FAIL done_latency: got %0d, want %0d", c, exp_done);
                end
                tests_run++;
                if (active_ways_o !== mask) begin
                    tests_failed++;
                    $display("FAIL active_after_done: got %b, want %b", active_ways_o, mask);
                end
                tests_run++;
                if (hold_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL idle_after_done: hold=%b ready=%b, want hold=0 ready=1",
                             hold_o, cfg_ready_o);
                end
            end else begin
                if (hold_o !== 1'b1 || cfg_ready_o !== 1'b0) ctl_err++;
                if (mem_req_o !== '0) begin
                    if (add == '0) req_err++;
                    if (mem_req_o !== add || mem_addr_o !== LINE_W'(writes) ||
                        mem_wdata_o !== '0 || mem_we_o !== 1'b1 || mem_be_o !== '1)
                        wr_err++;
                    if (stop_line >= 0 && writes == stop_line) begin
                        aborted = 1'b1;
                        break;
                    end
                    g = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? tog : 1'($urandom_range(0, 1));
                    tog = ~tog;
                    mem_gnt_i = g;
                    if (poke_cfg) begin
                        cfg_valid_i = 1'($urandom_range(0, 1));
                        cfg_ways_i  = NR_WAYS'($urandom);
                    end
                    if (g) begin
                        for (int w = 0; w < NR_WAYS; w++)
                            if (mem_req_o[w]) wr_cnt[w][mem_addr_o]++;
                        writes++;
                    end else begin
                        denied++;
                    end
                end
            end
            if (!done_seen) begin
                step();
                c++;
            end
        end

        tests_run++;
        if (ctl_err !== 0) begin
            tests_failed++;
            $display("FAIL hold_ready_busy: %0d bad cycles, want 0", ctl_err);
        end
        tests_run++;
        if (wr_err !== 0 || req_err !== 0) begin
            tests_failed++;
            $display("FAIL write_fields: %0d bad writes, %0d unexpected reqs, want 0", wr_err, req_err);
        end
        if (aborted) return;

        tests_run++;
        if (!done_seen) begin
            tests_failed++;
            $display("FAIL done_timeout: no done_o after %0d cycles", c);
        end
        tests_run++;
        if (writes !== ((add == '0) ? 0 : NUM_LINES)) begin
            tests_failed++;
            $display("FAIL write_count: got %0d, want %0d", writes, (add == '0) ? 0 : NUM_LINES);
        end
        for (int w = 0; w < NR_WAYS; w++) begin
            cnt_err = 0;
            for (int l = 0; l < NUM_LINES; l++)
                if (wr_cnt[w][l] != (add[w] ? 1 : 0)) cnt_err++;
            tests_run++;
            if (cnt_err !== 0) begin
                tests_failed++;
                $display("FAIL way%0d_lines: %0d lines with wrong write count, want 0 (added=%b)",
                         w, cnt_err, add[w]);
            end
        end
        exp_active = mask;
    endtask

    task automatic check_reset_outputs(input string tag);
        tests_run++;
        if (active_ways_o !== '0 || hold_o !== 1'b0 || done_o !== 1'b0 ||
            mem_req_o !== '0 || mem_addr_o !== '0 || cfg_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s: active=%b hold=%b done=%b req=%b addr=%0d ready=%b, want 0000 0 0 0000 0 1",
                     tag, active_ways_o, hold_o, done_o, mem_req_o, mem_addr_o, cfg_ready_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        check_reset_outputs("reset_values");
        rst_i = 1'b0;
        step();
        check_reset_outputs("idle_after_release");
        exp_active = '0;
    endtask

    task automatic test_first_fill();
        run_txn(4'b0011, 0, 1'b0, -1);
    endtask

    task automatic test_shrink();
        run_txn(4'b0001, 0, 1'b0, -1);
    endtask

    task automatic test_swap();
        run_txn(4'b0110, 0, 1'b0, -1);
    endtask

    task automatic test_gnt_toggle();
        run_txn(4'b1001, 1, 1'b0, -1);
    endtask

    task automatic test_cfg_ignored();
        run_txn(4'b0111, 2, 1'b1, -1);
    endtask

    task automatic test_same_mask();
        run_txn(exp_active, 0, 1'b0, -1);
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 4; i++)
            run_txn(NR_WAYS'($urandom_range(0, 15)), 2, 1'b0, -1);
    endtask

    task automatic test_reset_mid_clear();
        run_txn(4'b0000, 0, 1'b0, -1);
        run_txn(4'b1111, 0, 1'b0, 100);
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_outputs("async_reset_mid_clear");
        step();
        step();
        rst_i = 1'b0;
        exp_active = '0;
        for (int i = 0; i < 5; i++) step();
        check_reset_outputs("after_reset_release");
        run_txn(4'b0010, 0, 1'b0, -1);
    endtask

    initial begin
        rst_i       = 1'b1;
        cfg_ways_i  = '0;
        cfg_valid_i = 1'b0;
        mem_gnt_i   = 1'b0;
        exp_active  = '0;
        test_reset();
        test_first_fill();
        test_shrink();
        test_swap();
        test_gnt_toggle();
        test_cfg_ignored();
        test_same_mask();
        test_back_to_back_random();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
